// File: rtl/dif_radix2_64p_da_ctrl_pkg.sv
// Shared constants and state encoding for the 64-point DIF data-arrangement controller.
package dif_fft_pkg;

  localparam int unsigned FFT_RF_DEPTH = 8;
  localparam int unsigned FFT_ADDR_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    TURN,
    READ,
    DRAIN
  } da_ctrl_state_t;

endpackage

// File: rtl/dif_radix2_64p_da_ctrl_if.sv
// Sample-stream handshake plus register-file control bus between the controller and the DA block.
interface dif_radix2_64p_da_ctrl_if #(
  parameter int unsigned RF_DEPTH = dif_fft_pkg::FFT_RF_DEPTH,
  parameter int unsigned ADDR_W   = dif_fft_pkg::FFT_ADDR_W
);
  logic                in_valid;
  logic                in_ready;
  logic [RF_DEPTH-1:0] wen_ctrl;
  logic [ADDR_W-1:0]   waddr_ctrl;
  logic [RF_DEPTH-1:0] ren_ctrl;
  logic [ADDR_W-1:0]   raddr_ctrl;
  logic                out_valid;

  // master is the controller, which initiates all register-file traffic
  modport master (
    input  in_valid,
    output in_ready, wen_ctrl, waddr_ctrl, ren_ctrl, raddr_ctrl, out_valid
  );

  modport slave (
    output in_valid,
    input  in_ready, wen_ctrl, waddr_ctrl, ren_ctrl, raddr_ctrl, out_valid
  );
endinterface

// File: rtl/dif_radix2_64p_da_ctrl_delay.sv
// DEPTH-stage shift register aligning "read issued" with the DA block's registered dout.
module da_ctrl_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= (pipe << 1) | DEPTH'(din);
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/dif_radix2_64p_da_ctrl.sv
// Sequencer for dif_radix2_64p_da: writes a frame row-wise, then reads it back transposed.
module dif_radix2_64p_da_ctrl #(
  parameter int unsigned RF_DEPTH = dif_fft_pkg::FFT_RF_DEPTH,
  parameter int unsigned ADDR_W   = dif_fft_pkg::FFT_ADDR_W,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  dif_radix2_64p_da_ctrl_if.master        bus
);
  import dif_fft_pkg::*;

  localparam int unsigned CNT_W = 2 * ADDR_W;
  localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  da_ctrl_state_t      state_q;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    rd_nxt;
  logic [DRN_W-1:0]    drn_cnt;
  logic                in_ready_q;
  logic [RF_DEPTH-1:0] ren_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic                accept;
  logic                rd_issue;

  assign accept   = bus.in_valid && in_ready_q;
  assign rd_nxt   = rd_cnt + CNT_W'(1);
  assign rd_issue = (state_q == READ);

  // Write side: upper counter bits select the file, lower bits the entry (row-wise fill).
  assign bus.wen_ctrl   = accept ? (RF_DEPTH'(1) << wr_cnt[CNT_W-1 -: ADDR_W]) : '0;
  assign bus.waddr_ctrl = wr_cnt[ADDR_W-1:0];
  assign bus.in_ready   = in_ready_q;
  assign bus.ren_ctrl   = ren_q;
  assign bus.raddr_ctrl = raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      drn_cnt    <= '0;
      in_ready_q <= 1'b0;
      ren_q      <= '0;
      raddr_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped
          if (start && !done) begin
            state_q    <= WRITE;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
            wr_cnt     <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == '1) begin
              state_q    <= TURN;
              in_ready_q <= 1'b0;
            end
          end
        end
        TURN: begin
          state_q <= READ;
          rd_cnt  <= '0;
          ren_q   <= RF_DEPTH'(1);
          raddr_q <= '0;
        end
        READ: begin
          rd_cnt <= rd_nxt;
          // Registered outputs are preloaded from the next count; lower bits pick the file (column read).
          if (rd_cnt == '1) begin
            state_q <= DRAIN;
            ren_q   <= '0;
            raddr_q <= '0;
            drn_cnt <= '0;
          end else begin
            ren_q   <= RF_DEPTH'(1) << rd_nxt[ADDR_W-1:0];
            raddr_q <= rd_nxt[CNT_W-1 -: ADDR_W];
          end
        end
        DRAIN: begin
          if (drn_cnt == DRN_W'(RD_LAT - 1)) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drn_cnt <= drn_cnt + DRN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  da_ctrl_delay #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rd_issue),
    .dout  (bus.out_valid)
  );
endmodule

// File: tb/tb_dif_radix2_64p_da_ctrl.sv
// Directed bench for dif_radix2_64p_da_ctrl with a behavioural model of the DA register files.
module tb_dif_radix2_64p_da_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic [5:0] din;
  logic [5:0] dout;
  logic [5:0] rf [8][8];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  dif_radix2_64p_da_ctrl_if bus ();

  dif_radix2_64p_da_ctrl #(
    .RF_DEPTH (8),
    .ADDR_W   (3),
    .RD_LAT   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // DA block model: one-cycle registered read
  always @(posedge clk) begin
    for (int f = 0; f < 8; f++) begin
      if (bus.wen_ctrl[f]) rf[f][bus.waddr_ctrl] <= din;
      if (bus.ren_ctrl[f]) dout <= rf[f][bus.raddr_ctrl];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({bus.in_ready, bus.wen_ctrl, bus.waddr_ctrl, bus.ren_ctrl, bus.raddr_ctrl,
         bus.out_valid, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b wen=%h wa=%0d ren=%h ra=%0d ov=%b busy=%b done=%b expected all 0",
               tag, bus.in_ready, bus.wen_ctrl, bus.waddr_ctrl, bus.ren_ctrl, bus.raddr_ctrl,
               bus.out_valid, busy, done);
    end
  endtask

  // Entered at posedge+1 of the first WRITE cycle; returns at posedge+1 after the done cycle.
  task automatic frame_body(input bit gap, input bit pulse_w, input bit pulse_r, input bit start_at_done);
    int unsigned k = 0;
    int unsigned wcyc = 0;
    logic [7:0] exp_wen;
    logic [5:0] ev;
    bit v;
    while (k < 64 && wcyc < 400) begin
      v = gap ? (wcyc % 2 == 1) : 1'b1;
      bus.in_valid = v;
      din   = v ? 6'(k) : 6'h3f;
      start = pulse_w && (wcyc == 10);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL write_ready cyc=%0d: got rdy=%b busy=%b expected 1 1", wcyc, bus.in_ready, busy);
      end
      exp_wen = v ? 8'(1 << (k / 8)) : 8'h00;
      n_cmp++;
      if (bus.wen_ctrl !== exp_wen || bus.ren_ctrl !== 8'h00) begin
        n_bad++;
        $display("FAIL write_wen k=%0d: got wen=%h ren=%h expected wen=%h ren=00", k, bus.wen_ctrl, bus.ren_ctrl, exp_wen);
      end
      if (v) begin
        n_cmp++;
        if (bus.waddr_ctrl !== 3'(k % 8)) begin
          n_bad++;
          $display("FAIL write_addr k=%0d: got %0d expected %0d", k, bus.waddr_ctrl, k % 8);
        end
        k++;
      end
      wcyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.in_valid = 1'b1;
    din = 6'h2a;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.wen_ctrl !== 8'h00 || bus.ren_ctrl !== 8'h00 ||
        bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL turn: got rdy=%b wen=%h ren=%h ov=%b busy=%b expected 0 00 00 0 1",
               bus.in_ready, bus.wen_ctrl, bus.ren_ctrl, bus.out_valid, busy);
    end
    @(posedge clk); #1;
    for (int j = 0; j < 64; j++) begin
      start = pulse_r && (j == 20);
      @(negedge clk);
      n_cmp++;
      if (bus.ren_ctrl !== 8'(1 << (j % 8)) || bus.raddr_ctrl !== 3'(j / 8)) begin
        n_bad++;
        $display("FAIL read_addr j=%0d: got ren=%h ra=%0d expected ren=%h ra=%0d",
                 j, bus.ren_ctrl, bus.raddr_ctrl, 8'(1 << (j % 8)), j / 8);
      end
      n_cmp++;
      if (bus.wen_ctrl !== 8'h00 || bus.in_ready !== 1'b0 || busy !== 1'b1 || bus.out_valid !== (j > 0)) begin
        n_bad++;
        $display("FAIL read_ctl j=%0d: got wen=%h rdy=%b busy=%b ov=%b expected 00 0 1 %b",
                 j, bus.wen_ctrl, bus.in_ready, busy, bus.out_valid, j > 0);
      end
      if (j > 0) begin
        ev = 6'(((j - 1) % 8) * 8 + (j - 1) / 8);
        n_cmp++;
        if (dout !== ev) begin
          n_bad++;
          $display("FAIL read_data beat=%0d: got %0d expected %0d", j - 1, dout, ev);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ren_ctrl !== 8'h00 || bus.raddr_ctrl !== 3'd0 || bus.out_valid !== 1'b1 ||
        dout !== 6'd63 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL drain: got ren=%h ra=%0d ov=%b dout=%0d done=%b busy=%b expected 00 0 1 63 0 1",
               bus.ren_ctrl, bus.raddr_ctrl, bus.out_valid, dout, done, busy);
    end
    @(posedge clk); #1;
    start = start_at_done;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.ren_ctrl !== 8'h00) begin
      n_bad++;
      $display("FAIL done_pulse: got done=%b busy=%b ov=%b ren=%h expected 1 0 0 00",
               done, busy, bus.out_valid, bus.ren_ctrl);
    end
    @(posedge clk); #1;
    if (!start_at_done) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL after_done: got done=%b busy=%b rdy=%b expected 0 0 0", done, busy, bus.in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    din = '0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_immediate");
    repeat (4) @(posedge clk);
    #1 check_all_zero("reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_valid();
    bus.in_valid = 1'b1;
    din = 6'h15;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.wen_ctrl !== 8'h00 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_valid i=%0d: got wen=%h rdy=%b busy=%b expected 00 0 0", i, bus.wen_ctrl, bus.in_ready, busy);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start();
    frame_body(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gap();
    do_start();
    frame_body(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    do_start();
    frame_body(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL no_extra_frame: got busy=%b rdy=%b expected 0 0", busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      din = 6'(k);
      @(posedge clk); #1;
    end
    din = 6'd30;
    #1;
    n_cmp++;
    if (bus.wen_ctrl !== 8'h08 || bus.waddr_ctrl !== 3'd6) begin
      n_bad++;
      $display("FAIL sample30: got wen=%h wa=%0d expected 08 6", bus.wen_ctrl, bus.waddr_ctrl);
    end
    rst_n = 1'b0;
    #1 check_all_zero("reset_mid_write");
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    frame_body(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_done_start();
    do_start();
    frame_body(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_in_done: got busy=%b rdy=%b done=%b expected 0 0 0", busy, bus.in_ready, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    frame_body(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_valid();
    test_basic();
    test_gap();
    test_start_busy();
    test_reset_mid();
    test_done_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
